// File: rtl/vpu_wb_addr_gen.sv
// ---------------------------------------------------------------------------
// vpu_wb_addr_gen
//   Write-back address generator for the 24 VPU message memories (one per
//   column lane). Counts valid beats leaving the VPU pipeline and produces a
//   registered common write strobe plus one write address per lane. Lane k
//   writes beat b of a pass to (ROW_START_k + b) mod 2^ADDR_WIDTH, i.e. the
//   same diagonal the read side used, so results return to their source slots.
//   A pass is DEPTH beats; done pulses together with the final write.
//
// Ports
//   clk            in   clock
//   rst_n          in   asynchronous reset, active low
//   en             in   global enable; low stalls everything
//   start          in   one-cycle pulse: arm (or restart) a pass
//   vpu_out_valid  in   VPU output beat valid this cycle
//   wr_en          out  write strobe to all 24 lane memories
//   wr_addr        out  lane k address in bits [k*ADDR_WIDTH +: ADDR_WIDTH]
//   busy           out  pass in progress (state RUN)
//   done           out  one-cycle pulse on the final write of a pass
//   err_overrun    out  sticky: a valid beat arrived while not in RUN
//   dbg_state      out  current FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: vpu_out_valid has no ready; a beat is accepted exactly when it is
// sampled with en=1, start=0 and the FSM in RUN. Its write appears on wr_en /
// wr_addr on the following cycle. Any other valid beat is dropped.
// ---------------------------------------------------------------------------
module vpu_wb_addr_gen #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       start,
    input  logic                       vpu_out_valid,
    output logic                       wr_en,
    output logic [24*ADDR_WIDTH-1:0]   wr_addr,
    output logic                       busy,
    output logic                       done,
    output logic                       err_overrun,
    output logic                       dbg_state
);

    localparam int LANES = 24;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam int ROW_START [LANES] = '{
        9, 72, 177, 47, 198, 97, 94, 212, 30, 247, 10, 189,
        126, 18, 84, 57, 70, 36, 101, 42, 246, 35, 12, 106
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic [ADDR_WIDTH-1:0]   ptr_q [LANES];
    logic [ADDR_WIDTH-1:0]   ptr_d [LANES];
    logic [ADDR_WIDTH-1:0]   wr_addr_q [LANES];
    logic [ADDR_WIDTH-1:0]   wr_addr_d [LANES];
    logic                    wr_en_q, wr_en_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;

    logic                    last_beat;

    assign last_beat = (beat_cnt_q == CNT_W'(DEPTH - 1));

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        ptr_d      = ptr_q;
        wr_addr_d  = wr_addr_q;
        wr_en_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;

        if (en) begin
            // start wins over a coincident valid in both states: the beat is
            // dropped and the pass re-arms from its first beat.
            if (start) begin
                state_d    = ST_RUN;
                beat_cnt_d = '0;
                err_d      = 1'b0;
                for (int k = 0; k < LANES; k++) begin
                    ptr_d[k] = ADDR_WIDTH'(ROW_START[k]);
                end
            end else if (vpu_out_valid) begin
                case (state_q)
                    ST_IDLE: begin
                        err_d = 1'b1;
                    end
                    ST_RUN: begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ptr_q;
                        if (last_beat) begin
                            // Final beat: reload pointers so the next pass
                            // starts on the diagonal again.
                            done_d     = 1'b1;
                            state_d    = ST_IDLE;
                            beat_cnt_d = '0;
                            for (int k = 0; k < LANES; k++) begin
                                ptr_d[k] = ADDR_WIDTH'(ROW_START[k]);
                            end
                        end else begin
                            beat_cnt_d = beat_cnt_q + CNT_W'(1);
                            for (int k = 0; k < LANES; k++) begin
                                ptr_d[k] = ptr_q[k] + ADDR_WIDTH'(1);
                            end
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                ptr_q[k]     <= ADDR_WIDTH'(ROW_START[k]);
                wr_addr_q[k] <= ADDR_WIDTH'(ROW_START[k]);
            end
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            wr_en_q    <= wr_en_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            ptr_q      <= ptr_d;
            wr_addr_q  <= wr_addr_d;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane_out
        assign wr_addr[g*ADDR_WIDTH +: ADDR_WIDTH] = wr_addr_q[g];
    end

    assign wr_en       = wr_en_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign err_overrun = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_vpu_wb_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_vpu_wb_addr_gen
//   Directed scenarios followed by a randomized phase. A reference model
//   computes lane addresses as (ROW_START_k + beat_index) mod 256 and tracks
//   pass progress as a plain beat count; a compare process checks every
//   output on every falling edge, and write addresses through an expected
//   queue. Directed scenarios add literal expectations on logged addresses.
// ---------------------------------------------------------------------------
module tb_vpu_wb_addr_gen;

    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int LANES = 24;
    localparam int W     = LANES * AW;

    localparam int RS [LANES] = '{
        9, 72, 177, 47, 198, 97, 94, 212, 30, 247, 10, 189,
        126, 18, 84, 57, 70, 36, 101, 42, 246, 35, 12, 106
    };

    // ------------------------------------------------------------ clock/reset
    logic clk = 1'b0;
    logic rst_n;
    logic en, start, vpu_out_valid;
    logic wr_en, busy, done, err_overrun, dbg_state;
    logic [W-1:0] wr_addr;

    always #5 clk = ~clk;

    vpu_wb_addr_gen #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .start         (start),
        .vpu_out_valid (vpu_out_valid),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .busy          (busy),
        .done          (done),
        .err_overrun   (err_overrun),
        .dbg_state     (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ model
    bit           m_ready = 0;
    bit           m_run;
    int           m_beats;
    bit           e_wr_en, e_done, e_busy, e_err;
    logic [W-1:0] e_addr;
    logic [W-1:0] exp_q[$];

    function automatic logic [W-1:0] diag(input int beat);
        logic [W-1:0] v;
        for (int k = 0; k < LANES; k++) v[k*AW +: AW] = AW'((RS[k] + beat) % 256);
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready = 1;
            m_run   = 0;
            m_beats = 0;
            e_wr_en = 0;
            e_done  = 0;
            e_busy  = 0;
            e_err   = 0;
            e_addr  = diag(0);
            exp_q.delete();
        end else begin
            e_wr_en = 0;
            e_done  = 0;
            if (en) begin
                if (start) begin
                    m_run   = 1;
                    m_beats = 0;
                    e_err   = 0;
                end else if (vpu_out_valid) begin
                    if (!m_run) begin
                        e_err = 1;
                    end else begin
                        e_wr_en = 1;
                        e_addr  = diag(m_beats);
                        exp_q.push_back(e_addr);
                        m_beats++;
                        if (m_beats == DEPTH) begin
                            e_done  = 1;
                            m_run   = 0;
                            m_beats = 0;
                        end
                    end
                end
            end
            e_busy = m_run;
        end
    end

    // ------------------------------------------------------------ scoreboard
    int   done_cnt = 0;
    logic [AW-1:0] log0[$], log4[$], log9[$], log23[$];

    always @(negedge clk) begin
        if (m_ready) begin
            chk("wr_en", W'(wr_en), W'(e_wr_en));
            chk("done", W'(done), W'(e_done));
            chk("busy", W'(busy), W'(e_busy));
            chk("dbg_state", W'(dbg_state), W'(e_busy));
            chk("err_overrun", W'(err_overrun), W'(e_err));
            chk("wr_addr_hold", wr_addr, e_addr);
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", W'(1), W'(0));
                end else begin
                    chk("write_addr", wr_addr, exp_q.pop_front());
                end
                log0.push_back(wr_addr[0*AW +: AW]);
                log4.push_back(wr_addr[4*AW +: AW]);
                log9.push_back(wr_addr[9*AW +: AW]);
                log23.push_back(wr_addr[23*AW +: AW]);
            end
            if (done) done_cnt++;
        end
    end

    // ------------------------------------------------------------ drivers
    task automatic step(input logic e, input logic s, input logic v);
        en = e; start = s; vpu_out_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic beats(input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            int g;
            g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            for (int j = 0; j < g; j++) step(1, 0, 0);
            step(1, 0, 1);
        end
    endtask

    task automatic clear_logs();
        log0.delete(); log4.delete(); log9.delete(); log23.delete();
        done_cnt = 0;
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        rst_n = 0; en = 0; start = 0; vpu_out_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_lane0", W'(wr_addr[0*AW +: AW]), W'(9));
        chk("reset_lane23", W'(wr_addr[23*AW +: AW]), W'(106));
        chk("reset_busy", W'(busy), W'(0));
        #1 rst_n = 1;
        step(0, 0, 0);

        // 1: full contiguous pass
        clear_logs();
        step(1, 1, 0);
        beats(DEPTH, 0);
        step(1, 0, 0);
        chk("t1_busy_after", W'(busy), W'(0));
        step(1, 0, 0);
        chk("t1_writes", W'(log0.size()), W'(256));
        chk("t1_done_cnt", W'(done_cnt), W'(1));
        chk("t1_l0_first", W'(log0[0]), W'(9));
        chk("t1_l0_255", W'(log0[246]), W'(255));
        chk("t1_l0_wrap", W'(log0[247]), W'(0));
        chk("t1_l0_last", W'(log0[255]), W'(8));
        chk("t1_l9_first", W'(log9[0]), W'(247));
        chk("t1_l9_255", W'(log9[8]), W'(255));
        chk("t1_l9_wrap", W'(log9[9]), W'(0));
        chk("t1_l9_last", W'(log9[255]), W'(246));

        // 2: random gaps
        clear_logs();
        step(1, 1, 0);
        beats(DEPTH, 3);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("t2_writes", W'(log23.size()), W'(256));
        for (int i = 0; i < log23.size(); i++)
            chk("t2_l23_seq", W'(log23[i]), W'((106 + i) % 256));
        chk("t2_done_cnt", W'(done_cnt), W'(1));

        // 3: valid while idle
        clear_logs();
        step(1, 0, 1);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("t3_err_set", W'(err_overrun), W'(1));
        chk("t3_no_write", W'(log0.size()), W'(0));
        step(1, 1, 0);
        chk("t3_err_clr", W'(err_overrun), W'(0));

        // 4: stall mid-pass with valid held high
        clear_logs();
        beats(20, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1);
        chk("t4_stall_writes", W'(log4.size()), W'(20));
        beats(DEPTH - 20, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("t4_writes", W'(log4.size()), W'(256));
        for (int i = 0; i < log4.size(); i++)
            chk("t4_l4_seq", W'(log4[i]), W'((198 + i) % 256));

        // 5: restart after 100 beats, restart colliding with a valid
        clear_logs();
        step(1, 1, 0);
        beats(100, 0);
        step(1, 1, 1);
        beats(DEPTH - 1, 0);
        step(1, 0, 0);
        chk("t5_no_early_done", W'(done_cnt), W'(0));
        beats(1, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("t5_writes", W'(log0.size()), W'(356));
        chk("t5_l0_pre", W'(log0[99]), W'(108));
        chk("t5_l0_restart", W'(log0[100]), W'(9));
        chk("t5_l0_last", W'(log0[355]), W'(8));
        chk("t5_done_cnt", W'(done_cnt), W'(1));

        // 6: reset mid-pass
        clear_logs();
        step(1, 1, 0);
        beats(50, 0);
        en = 1; start = 0; vpu_out_valid = 1;
        #1 rst_n = 0;
        #1;
        chk("t6_lane2", W'(wr_addr[2*AW +: AW]), W'(177));
        chk("t6_busy", W'(busy), W'(0));
        chk("t6_wr_en", W'(wr_en), W'(0));
        @(posedge clk);
        #2 rst_n = 1;
        step(1, 0, 0);
        chk("t6_no_done", W'(done_cnt), W'(0));

        // random phase
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 399) == 0),
                 ($urandom_range(0, 9) < 7));
        end
        step(0, 0, 0);
        step(0, 0, 0);
        chk("final_exp_q_empty", W'(exp_q.size()), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
